cache_ctrl: RTL and testbench
=============================

// Module: cache_ctrl
// PURPOSE
//  2-way set-associative, write-through, no-write-allocate data cache.
//  Sits between the MEM stage and the SRAM controller; word-granular lines (32-bit).
//  Read hits complete in the request cycle. Read misses and all writes go to the SRAM controller.
//  The pipeline freezes while ready=0.
// PARAMETERS
//  SETS     64  number of sets, power of 2; INDEX_W = log2(SETS)
//  ADDR_W   32  byte-address width; TAG_W = ADDR_W-INDEX_W-2
// PORTS
//  clk             in   1       single clock, all state updates on rising edge
//  rst             in   1       synchronous, active-high reset
//  MEM_R_EN        in   1       load request from MEM stage (held until ready=1)
//  MEM_W_EN        in   1       store request from MEM stage (held until ready=1)
//  address         in   ADDR_W  byte address; [1:0] ignored
//  write_data      in   32      store data
//  read_data       out  32      load data, valid when ready=1 && MEM_R_EN
//  ready           out  1       request complete / stage may advance
//  sram_r_en       out  1       read request to SRAM controller
//  sram_w_en       out  1       write request to SRAM controller
//  sram_address    out  ADDR_W  = address (pass-through, unmodified byte address)
//  sram_write_data out  32      = write_data
//  sram_read_data  in   32      SRAM read data, valid when sram_ready=1 during READ
//  sram_ready      in   1       SRAM op complete (1-cycle pulse while enable held)
// BEHAVIOUR
//  Fields: index=address[INDEX_W+1:2], tag=address[ADDR_W-1:INDEX_W+2].
//  Per set: valid[2], tag[2], data[2], lru (1 bit = way to evict next).
//  hit_w = valid[w] && tag[w]==tag; hit = hit0|hit1; hit0 and hit1 never both 1.
//  FSM: IDLE, READ, WRITE. Reset -> IDLE; all valid=0, all lru=0.
//  During rst: sram_r_en=0, sram_w_en=0, read_data=0, ready=~(MEM_R_EN|MEM_W_EN).
//  The tag/data arrays need no reset.
//  IDLE:
//   MEM_W_EN=1 -> ready=0, next WRITE. MEM_W_EN has priority if both enables are 1.
//   MEM_R_EN && hit -> ready=1, read_data=data[hit way] (combinational, 0 wait); lru<=~hitway; stay IDLE.
//   MEM_R_EN && !hit -> ready=0, next READ.
//   no request -> ready=1, read_data=0.
//  READ: sram_r_en=1, ready=sram_ready, read_data=sram_read_data.
//   On sram_ready=1: fill the victim way.
//    victim = way0 if !valid0; else way1 if !valid1; else lru.
//    Fill sets valid=1, tag, data=sram_read_data, lru<=~victim.
//   Next state IDLE.
//  WRITE: sram_w_en=1, ready=sram_ready.
//   On sram_ready=1: if hit, data[hitway]<=write_data and lru<=~hitway.
//   On a miss no allocation and lru is unchanged. Next state IDLE.
//  sram_ready is ignored in IDLE (the SRAM controller drives it 1 when idle).
//  sram_r_en and sram_w_en are registered by state: never both 1, and 0 in IDLE.
//  Enables drop the cycle after sram_ready, so the controller sees one op per request.
//  Upstream holds address/write_data/enables stable while ready=0.
//  A change in that window is a protocol violation: behaviour undefined, no assertion in RTL.
//  Latency: read hit 0 extra cycles.
//   Miss/write: 1 (IDLE decode) + N cycles, N = SRAM controller latency.
//   ready=1 in the cycle sram_ready=1.
//  rst asserted mid-READ/WRITE: abort to IDLE next edge, no fill, enables 0 next cycle.
//  Addresses differing only in [1:0] map to the same word.
// TESTING
//  1. rst, then load 0x400 with SRAM model ready after 7 cycles, data 0xDEADBEEF.
//     -> sram_r_en high cycles 1..7, ready=1 cycle 7, read_data=0xDEADBEEF.
//  2. Repeat load 0x400 -> ready=1 same cycle, sram_r_en never asserted, read_data=0xDEADBEEF.
//  3. Loads 0x400, 0x500, 0x600 (same index, SETS=64) -> third evicts 0x400 (lru).
//     Reload 0x500 hits; reload 0x400 misses.
//  4. Store 0x500 <- 0x12345678 (hit) -> sram_w_en pulse until sram_ready.
//     Following load 0x500 hits, returns 0x12345678.
//  5. Store 0x700 (miss) -> SRAM written once; later load 0x700 misses (no allocate).
//  6. rst asserted during READ cycle 3 -> IDLE, enables 0 next cycle; reload 0x400 misses.
//     MEM_R_EN=MEM_W_EN=1 -> handled as write.

Source files
------------

// File: rtl/cache_if.sv
// cache_if: MEM-stage request/response plus SRAM-controller side of the data cache
interface cache_if #(parameter int ADDR_W = 32);
  logic              MEM_R_EN;
  logic              MEM_W_EN;
  logic [ADDR_W-1:0] address;
  logic [31:0]       write_data;
  logic [31:0]       read_data;
  logic              ready;
  logic              sram_r_en;
  logic              sram_w_en;
  logic [ADDR_W-1:0] sram_address;
  logic [31:0]       sram_write_data;
  logic [31:0]       sram_read_data;
  logic              sram_ready;
  modport slave (
    input  MEM_R_EN, MEM_W_EN, address, write_data, sram_read_data, sram_ready,
    output read_data, ready, sram_r_en, sram_w_en, sram_address, sram_write_data
  );
  modport master (
    output MEM_R_EN, MEM_W_EN, address, write_data, sram_read_data, sram_ready,
    input  read_data, ready, sram_r_en, sram_w_en, sram_address, sram_write_data
  );
endinterface

// File: rtl/cache_ctrl.sv
// cache_ctrl: 2-way set-associative write-through no-write-allocate word cache in front of an SRAM controller
module cache_ctrl #(
  parameter int SETS   = 64,
  parameter int ADDR_W = 32
) (
  input logic    clk,
  input logic    rst,
  cache_if.slave bus
);
  localparam int INDEX_W = $clog2(SETS);
  localparam int TAG_W   = ADDR_W - INDEX_W - 2;
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  state_t             state;
  logic [1:0]         valid [SETS];
  logic [TAG_W-1:0]   tags  [SETS][2];
  logic [31:0]        data  [SETS][2];
  logic [SETS-1:0]    lru;
  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tg;
  logic               hit0, hit1, hit, hway, victim;
  always_comb begin
    idx    = bus.address[INDEX_W+1:2];
    tg     = bus.address[ADDR_W-1:INDEX_W+2];
    hit0   = valid[idx][0] && tags[idx][0] == tg;
    hit1   = valid[idx][1] && tags[idx][1] == tg;
    hit    = hit0 | hit1;
    hway   = hit1;
    victim = !valid[idx][0] ? 1'b0 : !valid[idx][1] ? 1'b1 : lru[idx];
  end
  // enables follow the registered state; rst masks them so an abort is clean
  always_comb begin
    bus.sram_r_en       = !rst && state == READ;
    bus.sram_w_en       = !rst && state == WRITE;
    bus.sram_address    = bus.address;
    bus.sram_write_data = bus.write_data;
    bus.ready     = rst ? !(bus.MEM_R_EN || bus.MEM_W_EN) :
                    state == IDLE ? !bus.MEM_W_EN && (!bus.MEM_R_EN || hit) : bus.sram_ready;
    bus.read_data = rst ? 32'h0 :
                    state == READ ? bus.sram_read_data :
                    (state == IDLE && bus.MEM_R_EN && !bus.MEM_W_EN && hit) ? data[idx][hway] : 32'h0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      valid <= '{default: '0};
      lru   <= '0;
    end else begin
      case (state)
        IDLE:
          if (bus.MEM_W_EN) state <= WRITE;
          else if (bus.MEM_R_EN) begin
            if (hit) lru[idx] <= !hway;
            else state <= READ;
          end
        READ:
          if (bus.sram_ready) begin
            valid[idx][victim] <= 1'b1;
            tags[idx][victim]  <= tg;
            data[idx][victim]  <= bus.sram_read_data;
            lru[idx]           <= !victim;
            state              <= IDLE;
          end
        WRITE:
          if (bus.sram_ready) begin
            if (hit) begin
              data[idx][hway] <= bus.write_data;
              lru[idx]        <= !hway;
            end
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed and random accesses checked against a recency-list cache model and a word memory
module tb_cache_ctrl;
  localparam int SETS = 64;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  cache_if #(.ADDR_W(32)) bus();
  cache_ctrl #(.SETS(SETS), .ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  int lat = 1;
  int cnt = 0;
  int wcount = 0;
  logic [31:0] mem [int];
  logic [29:0] res [$];
  // SRAM controller: ready while idle, otherwise pulses in the lat-th enabled cycle
  assign bus.sram_ready = !(bus.sram_r_en || bus.sram_w_en) || cnt == lat - 1;
  always @(posedge clk) begin
    cnt <= ((bus.sram_r_en || bus.sram_w_en) && !bus.sram_ready) ? cnt + 1 : 0;
    if (bus.sram_w_en && bus.sram_ready) wcount <= wcount + 1;
  end
  function automatic logic [31:0] word(input logic [31:0] a);
    return mem.exists(int'(a[31:2])) ? mem[int'(a[31:2])] : (a * 32'h9E3779B1) ^ 32'h5A5A_0F0F;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.MEM_R_EN = 1'b0;
    bus.MEM_W_EN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_sram_r_en", 32'(bus.sram_r_en), 32'd0);
    chk("rst_sram_w_en", 32'(bus.sram_w_en), 32'd0);
    chk("rst_read_data", bus.read_data, 32'h0);
    rst = 1'b0;
    res.delete();
  endtask
  task automatic access(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d, input int l);
    logic [29:0] wa = a[31:2];
    logic [31:0] exp = word(a);
    int pos = -1;
    int n = 0;
    int cycles = 0;
    int sr = 0;
    int sw = 0;
    int w0 = wcount;
    bit hit, timeout = 1'b0;
    foreach (res[i]) if (res[i] == wa) pos = i;
    hit = pos >= 0;
    lat = l;
    bus.sram_read_data = exp;
    bus.address = a;
    bus.write_data = d;
    bus.MEM_R_EN = r;
    bus.MEM_W_EN = w;
    while (1) begin
      @(negedge clk);
      if (bus.sram_r_en) sr++;
      if (bus.sram_w_en) sw++;
      if (bus.ready) break;
      cycles++;
      if (cycles > 200) begin
        timeout = 1'b1;
        break;
      end
    end
    chk("timeout", 32'(timeout), 32'd0);
    chk("sram_address", bus.sram_address, a);
    if (w) begin
      chk("wr_cycles", 32'(cycles), 32'(l));
      chk("wr_sram_w_en_cycles", 32'(sw), 32'(l));
      chk("wr_sram_r_en_cycles", 32'(sr), 32'd0);
      chk("sram_write_data", bus.sram_write_data, d);
    end else begin
      chk(hit ? "rd_hit_cycles" : "rd_miss_cycles", 32'(cycles), hit ? 32'd0 : 32'(l));
      chk("rd_sram_r_en_cycles", 32'(sr), hit ? 32'd0 : 32'(l));
      chk("rd_sram_w_en_cycles", 32'(sw), 32'd0);
      chk("read_data", bus.read_data, exp);
    end
    @(posedge clk);
    #1;
    bus.MEM_R_EN = 1'b0;
    bus.MEM_W_EN = 1'b0;
    chk("sram_write_count", 32'(wcount - w0), w ? 32'd1 : 32'd0);
    if (w) mem[int'(wa)] = d;
    if (hit) begin
      res.delete(pos);
      res.push_front(wa);
    end else if (!w) begin
      pos = -1;
      foreach (res[i]) if (res[i][5:0] == wa[5:0]) begin
        n++;
        pos = i;
      end
      if (n == 2) res.delete(pos);
      res.push_front(wa);
    end
  endtask
  initial begin
    bus.MEM_R_EN = 1'b0;
    bus.MEM_W_EN = 1'b0;
    bus.address = '0;
    bus.write_data = '0;
    bus.sram_read_data = '0;
    do_reset();
    mem[32'h400 >> 2] = 32'hDEADBEEF;
    access(1, 0, 32'h400, 0, 7);
    access(1, 0, 32'h400, 0, 7);
    access(1, 0, 32'h500, 0, 3);
    access(1, 0, 32'h600, 0, 3);
    access(1, 0, 32'h500, 0, 3);
    access(1, 0, 32'h403, 0, 3);
    access(0, 1, 32'h500, 32'h12345678, 4);
    access(1, 0, 32'h502, 0, 4);
    access(0, 1, 32'h700, 32'hCAFEF00D, 2);
    access(1, 0, 32'h700, 0, 2);
    access(1, 1, 32'h800, 32'hAAAA5555, 3);
    access(1, 0, 32'h800, 0, 3);
    // reset in the third READ cycle of a miss
    lat = 10;
    bus.address = 32'h900;
    bus.sram_read_data = word(32'h900);
    bus.MEM_R_EN = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_pre_sram_r_en", 32'(bus.sram_r_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_rst_sram_r_en", 32'(bus.sram_r_en), 32'd0);
    chk("abort_rst_ready", 32'(bus.ready), 32'd0);
    chk("abort_rst_read_data", bus.read_data, 32'h0);
    @(negedge clk);
    chk("abort_next_sram_r_en", 32'(bus.sram_r_en), 32'd0);
    chk("abort_next_sram_w_en", 32'(bus.sram_w_en), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.MEM_R_EN = 1'b0;
    res.delete();
    access(1, 0, 32'h400, 0, 2);
    access(1, 0, 32'h900, 0, 2);
    for (int i = 0; i < 80; i++) begin
      logic [31:0] a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      int k = $urandom_range(0, 9);
      access(k < 7 || k == 9, k >= 7, a, $urandom, $urandom_range(1, 5));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
